// File: rtl/wb_clint_pkg.sv
// Shared definitions for the CLINT timer: register word offsets, reset constants,
// register-select decode and the byte-lane write merge helper.
package wb_clint_pkg;

   localparam logic [5:0] OFF_MSIP        = 6'h00;
   localparam logic [5:0] OFF_MTIMECMP_LO = 6'h02;
   localparam logic [5:0] OFF_MTIMECMP_HI = 6'h03;
   localparam logic [5:0] OFF_MTIME_LO    = 6'h04;
   localparam logic [5:0] OFF_MTIME_HI    = 6'h05;
   localparam logic [5:0] OFF_PRESCALE    = 6'h06;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      REG_MSIP,
      REG_MTIMECMP_LO,
      REG_MTIMECMP_HI,
      REG_MTIME_LO,
      REG_MTIME_HI,
      REG_PRESCALE,
      REG_NONE
   } reg_sel_e;

   // Offsets are word indices taken from adr[7:2].
   function automatic reg_sel_e decode_reg(input logic [5:0] word);
      reg_sel_e sel;
      case (word)
         OFF_MSIP:        sel = REG_MSIP;
         OFF_MTIMECMP_LO: sel = REG_MTIMECMP_LO;
         OFF_MTIMECMP_HI: sel = REG_MTIMECMP_HI;
         OFF_MTIME_LO:    sel = REG_MTIME_LO;
         OFF_MTIME_HI:    sel = REG_MTIME_HI;
         OFF_PRESCALE:    sel = REG_PRESCALE;
         default:         sel = REG_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_word;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: emits a one-cycle tick every div+1 clocks; a clear
// restarts the count from zero on the same edge.
module clint_tick_gen
   import wb_clint_pkg::*;
#(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PRESCALE_W-1:0] div,
   input  logic                  clear,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == div);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (clear) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/wb_clint_timer.sv
// Wishbone classic CLINT slave: 64-bit mtime/mtimecmp, msip and tick prescaler,
// driving the machine timer and software interrupt lines.
module wb_clint_timer
   import wb_clint_pkg::*;
#(
   parameter int                    PRESCALE_W  = 16,
   parameter logic [PRESCALE_W-1:0] DEFAULT_DIV = '0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic [2:0]  wb_cti_i,
   input  logic [1:0]  wb_bte_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic        timer_irq_o,
   output logic        soft_irq_o
);

   logic                  ack_q, ack_d, err_q, err_d;
   logic [31:0]           dat_q, dat_d;
   logic                  msip_q, msip_d;
   logic [63:0]           mtimecmp_q, mtimecmp_d;
   logic [63:0]           mtime_q, mtime_d;
   logic [31:0]           hi_shadow_q, hi_shadow_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic                  timer_irq_q, timer_irq_d;

   reg_sel_e    reg_sel;
   logic        accept, wr, rd, prescale_wr, tick;
   logic [31:0] rdata, cur_word, wr_word;
   logic        unused_bus;

   assign unused_bus = ^{wb_adr_i[31:8], wb_adr_i[1:0], wb_cti_i, wb_bte_i};

   always_comb begin
      reg_sel     = decode_reg(wb_adr_i[7:2]);
      accept      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
      wr          = accept & wb_we_i & (reg_sel != REG_NONE);
      rd          = accept & ~wb_we_i & (reg_sel != REG_NONE);
      prescale_wr = wr & (reg_sel == REG_PRESCALE);
   end

   // Read data for the bus; writes merge into the live word, so MTIME_HI uses
   // the counter itself rather than the read shadow.
   always_comb begin
      rdata = '0;
      case (reg_sel)
         REG_MSIP:        rdata[0] = msip_q;
         REG_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
         REG_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
         REG_MTIME_LO:    rdata = mtime_q[31:0];
         REG_MTIME_HI:    rdata = hi_shadow_q;
         REG_PRESCALE:    rdata[PRESCALE_W-1:0] = prescale_q;
         default:         rdata = '0;
      endcase
      cur_word = (reg_sel == REG_MTIME_HI) ? mtime_q[63:32] : rdata;
      wr_word  = merge_bytes(cur_word, wb_dat_i, wb_sel_i);
   end

   clint_tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick_gen (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .div   (prescale_q),
      .clear (prescale_wr),
      .tick  (tick)
   );

   always_comb begin
      ack_d       = accept & (reg_sel != REG_NONE);
      err_d       = accept & (reg_sel == REG_NONE);
      dat_d       = accept ? rdata : dat_q;
      msip_d      = msip_q;
      mtimecmp_d  = mtimecmp_q;
      mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
      hi_shadow_d = hi_shadow_q;
      prescale_d  = prescale_q;
      timer_irq_d = (mtime_q >= mtimecmp_q);
      // A software write to either mtime half wins over the tick for the whole counter.
      if (wr) begin
         case (reg_sel)
            REG_MSIP:        msip_d = wr_word[0];
            REG_MTIMECMP_LO: mtimecmp_d[31:0] = wr_word;
            REG_MTIMECMP_HI: mtimecmp_d[63:32] = wr_word;
            REG_MTIME_LO:    mtime_d = {mtime_q[63:32], wr_word};
            REG_MTIME_HI:    mtime_d = {wr_word, mtime_q[31:0]};
            REG_PRESCALE:    prescale_d = wr_word[PRESCALE_W-1:0];
            default:         msip_d = msip_q;
         endcase
      end
      if (rd && (reg_sel == REG_MTIME_LO)) hi_shadow_d = mtime_q[63:32];
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         dat_q       <= '0;
         msip_q      <= 1'b0;
         mtimecmp_q  <= MTIMECMP_RST;
         mtime_q     <= '0;
         hi_shadow_q <= '0;
         prescale_q  <= DEFAULT_DIV;
         timer_irq_q <= 1'b0;
      end else begin
         ack_q       <= ack_d;
         err_q       <= err_d;
         dat_q       <= dat_d;
         msip_q      <= msip_d;
         mtimecmp_q  <= mtimecmp_d;
         mtime_q     <= mtime_d;
         hi_shadow_q <= hi_shadow_d;
         prescale_q  <= prescale_d;
         timer_irq_q <= timer_irq_d;
      end
   end

   assign wb_dat_o    = dat_q;
   assign wb_ack_o    = ack_q;
   assign wb_err_o    = err_q;
   assign wb_rty_o    = 1'b0;
   assign timer_irq_o = timer_irq_q;
   assign soft_irq_o  = msip_q;

endmodule

// File: tb/tb_wb_clint_timer.sv
// Directed bench for wb_clint_timer: register access, compare interrupt timing,
// prescaled ticking, coherent 64-bit reads, msip byte enables and async reset.
module tb_wb_clint_timer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_we_i, wb_cyc_i, wb_stb_i;
   logic [2:0]  wb_cti_i;
   logic [1:0]  wb_bte_i;
   logic        wb_ack_o, wb_err_o, wb_rty_o, timer_irq_o, soft_irq_o;

   int          checks = 0;
   int          errors = 0;
   logic        bus_ack, bus_err;
   logic [31:0] bus_dat;

   wb_clint_timer dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_sel_i    (wb_sel_i),
      .wb_we_i     (wb_we_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_cti_i    (wb_cti_i),
      .wb_bte_i    (wb_bte_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
      .wb_err_o    (wb_err_o),
      .wb_rty_o    (wb_rty_o),
      .timer_irq_o (timer_irq_o),
      .soft_irq_o  (soft_irq_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One classic access: accepted on the first rising edge, strobe dropped
   // before the next one, returns 1ns after the edge where ack falls.
   task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                                input logic [3:0] sel, input logic we);
      @(negedge clk);
      wb_adr_i = adr;
      wb_dat_i = dat;
      wb_sel_i = sel;
      wb_we_i  = we;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(posedge clk);
      #1;
      bus_ack  = wb_ack_o;
      bus_err  = wb_err_o;
      bus_dat  = wb_dat_o;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      wb_adr_i = '0;
      wb_dat_i = '0;
      wb_sel_i = '0;
      wb_we_i  = 1'b0;
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_cti_i = 3'b111;
      wb_bte_i = 2'b01;
      repeat (3) @(negedge clk);
      checkOutput("rst_ack", wb_ack_o, 0);
      checkOutput("rst_err", wb_err_o, 0);
      checkOutput("rst_dat", wb_dat_o, 0);
      checkOutput("rst_timer_irq", timer_irq_o, 0);
      checkOutput("rst_soft_irq", soft_irq_o, 0);
      rst = 1'b0;

      applyStimulus(32'h2000_0C0C, 0, 4'h0, 1'b0);
      checkOutput("cmp_hi_rst_ack", bus_ack, 1);
      checkOutput("cmp_hi_rst_dat", bus_dat, 32'hFFFF_FFFF);
      applyStimulus(32'h2000_0C08, 0, 4'h0, 1'b0);
      checkOutput("cmp_lo_rst_ack", bus_ack, 1);
      checkOutput("cmp_lo_rst_dat", bus_dat, 32'hFFFF_FFFF);
      applyStimulus(32'h2000_0C1C, 0, 4'h0, 1'b0);
      checkOutput("unmapped_rd_err", bus_err, 1);
      checkOutput("unmapped_rd_ack", bus_ack, 0);
      checkOutput("unmapped_rd_dat", bus_dat, 0);
      applyStimulus(32'h2000_0C04, 32'h1234, 4'hF, 1'b1);
      checkOutput("unmapped_wr_err", bus_err, 1);
      applyStimulus(32'h2000_0C18, 0, 4'h0, 1'b0);
      checkOutput("prescale_rst", bus_dat, 0);
      checkOutput("rty", wb_rty_o, 0);

      // mtime=0 written at edge A, compare at 20 -> irq visible from edge A+21.
      applyStimulus(32'h2000_0C14, 0, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C10, 0, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C0C, 0, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C08, 20, 4'hF, 1'b1);
      repeat (15) @(posedge clk);
      #1;
      checkOutput("irq_before_cmp", timer_irq_o, 0);
      @(posedge clk);
      #1;
      checkOutput("irq_at_cmp", timer_irq_o, 1);
      applyStimulus(32'h2000_0C08, 100, 4'hF, 1'b1);
      checkOutput("irq_cleared", timer_irq_o, 0);

      // PRESCALE=3 at edge C, mtime_lo=0 at C+2, ticks at C+4, C+8, ...
      applyStimulus(32'h2000_0C18, 3, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C10, 0, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("presc_c4", bus_dat, 0);
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("presc_c6", bus_dat, 1);
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("presc_c8", bus_dat, 1);
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("presc_c10", bus_dat, 2);
      repeat (34) @(posedge clk);
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("presc_c46", bus_dat, 11);
      applyStimulus(32'h2000_0C18, 0, 4'h0, 1'b0);
      checkOutput("prescale_rd", bus_dat, 3);

      // Carry across the 32-bit boundary and coherent LO/HI read.
      applyStimulus(32'h2000_0C18, 0, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C14, 0, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C10, 32'hFFFF_FFFF, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("wrap_lo", bus_dat, 0);
      applyStimulus(32'h2000_0C14, 0, 4'h0, 1'b0);
      checkOutput("wrap_hi", bus_dat, 1);

      // PRESCALE=3 at G, write MTIME_LO in the tick cycle G+4.
      applyStimulus(32'h2000_0C18, 3, 4'hF, 1'b1);
      repeat (2) @(posedge clk);
      applyStimulus(32'h2000_0C10, 32'hFFFF_FFFF, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("tickwr_lo", bus_dat, 32'hFFFF_FFFF);
      applyStimulus(32'h2000_0C14, 0, 4'h0, 1'b0);
      checkOutput("tickwr_hi", bus_dat, 1);

      applyStimulus(32'h2000_0C00, 1, 4'b0001, 1'b1);
      checkOutput("msip_set", soft_irq_o, 1);
      applyStimulus(32'h2000_0C00, 0, 4'b0000, 1'b1);
      checkOutput("msip_nosel", soft_irq_o, 1);
      applyStimulus(32'h2000_0C00, 0, 4'h0, 1'b0);
      checkOutput("msip_rd", bus_dat, 1);
      applyStimulus(32'h2000_0C00, 0, 4'b0001, 1'b1);
      checkOutput("msip_clr", soft_irq_o, 0);
      applyStimulus(32'h2000_0C00, 32'hFFFF_FFFF, 4'hF, 1'b1);
      applyStimulus(32'h2000_0C00, 0, 4'h0, 1'b0);
      checkOutput("msip_upper_zero", bus_dat, 1);
      checkOutput("irq_high_pre_rst", timer_irq_o, 1);

      // Reset while a write is being acknowledged.
      @(negedge clk);
      wb_adr_i = 32'h2000_0C08;
      wb_dat_i = 5;
      wb_sel_i = 4'hF;
      wb_we_i  = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("pre_rst_ack", wb_ack_o, 1);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async_ack_drop", wb_ack_o, 0);
      checkOutput("async_timer_irq", timer_irq_o, 0);
      checkOutput("async_soft_irq", soft_irq_o, 0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      applyStimulus(32'h2000_0C10, 0, 4'h0, 1'b0);
      checkOutput("post_rst_mtime_lo", bus_dat, 1);
      applyStimulus(32'h2000_0C14, 0, 4'h0, 1'b0);
      checkOutput("post_rst_mtime_hi", bus_dat, 0);
      applyStimulus(32'h2000_0C08, 0, 4'h0, 1'b0);
      checkOutput("post_rst_cmp_lo", bus_dat, 32'hFFFF_FFFF);
      applyStimulus(32'h2000_0C0C, 0, 4'h0, 1'b0);
      checkOutput("post_rst_cmp_hi", bus_dat, 32'hFFFF_FFFF);
      applyStimulus(32'h2000_0C18, 0, 4'h0, 1'b0);
      checkOutput("post_rst_prescale", bus_dat, 0);
      checkOutput("post_rst_timer_irq", timer_irq_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_clint_timer.md
# wb_clint_timer

Wishbone classic slave implementing the core-local interruptor (CLINT): a 64-bit free-running `mtime` counter, a 64-bit `mtimecmp` compare register, the machine software-interrupt bit `msip`, and a programmable tick prescaler. It is the responder on the interconnect's CLINT slave port, decoded at 0x20000C00–0x20000CFF. It drives the core's machine timer and software interrupt lines.

## Interface
- `PRESCALE_W`, 16: width of prescaler divider register/counter.
- `DEFAULT_DIV`, 16'd0: reset value of PRESCALE; `mtime` ticks every DIV+1 clocks.
- `wb_clk_i`  in  1  system clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wb_adr_i`  in  32  byte address; only [7:2] decoded.
- `wb_dat_i`  in  32  write data.
- `wb_sel_i`  in  4  byte enables for writes.
- `wb_we_i`  in  1  write strobe.
- `wb_cyc_i`  in  1  bus cycle.
- `wb_stb_i`  in  1  strobe.
- `wb_cti_i`  in  3  ignored; every access is treated as classic single.
- `wb_bte_i`  in  2  ignored.
- `wb_dat_o`  out  32  read data, valid with ack.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination for unmapped offset.
- `wb_rty_o`  out  1  tied 0.
- `timer_irq_o`  out  1  registered `mtime >= mtimecmp` (unsigned).
- `soft_irq_o`  out  1  equals `msip`.

## Operation
- Register map (offset = adr[7:0]): 0x00 MSIP (bit0, rest read 0); 0x08 MTIMECMP_LO; 0x0C MTIMECMP_HI; 0x10 MTIME_LO; 0x14 MTIME_HI; 0x18 PRESCALE (bits [PRESCALE_W-1:0], upper read 0). Any other offset → err instead of ack, no state change, dat_o = 0.
- Reset values: `msip` 0, `mtimecmp` all ones, `mtime` 0, PRESCALE `DEFAULT_DIV`, prescale counter 0, hi-shadow 0; outputs ack/err/irqs 0, dat_o 0.
- Writes honour `wb_sel_i` per byte; unselected bytes keep their value.
- Tick: prescale counter increments each clock; when it equals PRESCALE it clears and a tick pulses; tick increments `mtime` by 1 with 64-bit wrap (all ones → 0).
- Writing PRESCALE clears the prescale counter in the same edge.
- Write to MTIME_LO or MTIME_HI in a tick cycle: written halves take their new value, the increment is suppressed entirely that cycle (no carry into the other half).
- Read of MTIME_LO returns live low word and captures live high word into a hi-shadow; read of MTIME_HI returns the shadow. Read order LO then HI gives a coherent 64-bit sample.
- `timer_irq_o` is level, recomputed every clock from post-update registers of the previous cycle; clears only when software raises `mtimecmp` or writes `mtime` below it.

## Timing
- Access accepted when `cyc & stb & !ack & !err`; ack/err asserted exactly one cycle later for one cycle, then dropped; a master holding stb gets one termination per two clocks (no back-to-back ack).
- Write side effects take place on the accept edge; read data registered on the accept edge and held with ack.
- `cyc` dropped before termination: pending termination still issues the next cycle and is ignored by the master; no state rollback.
- `timer_irq_o` lags the compare condition by one cycle; `soft_irq_o` follows `msip` with no added latency.
- Reset mid-access: ack/err drop immediately (async), all registers return to reset values.

## Structure
- `wb_clint_pkg`: register offset constants, `MTIMECMP_RST` (64'hFFFF_FFFF_FFFF_FFFF), decode enum for register select.
- Sub-module `clint_tick_gen`: prescale counter, divider compare, counter clear on PRESCALE write; outputs single-cycle `tick`.

## Test plan
- Reset, read 0x0C/0x08 → 0xFFFFFFFF each with ack; read 0x1C → err=1, ack=0, dat_o=0.
- DIV=0: write MTIMECMP={0,20}, MTIME={0,0}; `timer_irq_o` rises on the clock after `mtime` reaches 20; writing MTIMECMP_LO=100 clears it one cycle later.
- Write PRESCALE=3; `mtime` increments exactly every 4 clocks over 40 clocks (10 increments).
- Write MTIME={0,0xFFFFFFFF}, tick, read LO then HI → 0x00000000 / 0x00000001; then write MTIME_LO in a tick cycle and check the written value exactly with HI unchanged.
- Write MSIP with sel=4'b0001, data=1 → `soft_irq_o`=1; write sel=4'b0000 → unchanged; data=0, sel=1 → 0.
- Assert `wb_rst_i` while a write is being acked → ack drops asynchronously, `mtime`=0, `mtimecmp` all ones, irqs 0.
